// File: rtl/vram_display_reader_if.sv
// VRAM read-port bundle between the display reader (master) and the frame-buffer RAM (slave).
interface vram_display_reader_if #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned DATA_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] pixel_read_address_o;
    logic [DATA_WIDTH-1:0] pixel_data_i;

    modport master (output pixel_read_address_o, input pixel_data_i);
    modport slave  (input pixel_read_address_o, output pixel_data_i);
endinterface

// File: rtl/vram_display_reader.sv
// Frame-buffer read side: VGA timing from the system clock, 2x-scaled VRAM fetch,
// and a registered sync/colour output stage aligned one tick behind the address.
module vram_display_reader #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned FB_WIDTH   = 320,
    parameter int unsigned FB_HEIGHT  = 240,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    vram_display_reader_if.master  vram,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic [3:0]             red_o,
    output logic [3:0]             green_o,
    output logic [3:0]             blue_o,
    output logic                   active_o,
    output logic                   frame_start_o
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_W      = $clog2(H_TOTAL);
    localparam int unsigned V_W      = $clog2(V_TOTAL);
    localparam int unsigned DIV_W    = $clog2(CLK_DIV);
    localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    if (CLK_DIV < 2) begin : g_bad_div
        $error("CLK_DIV must be at least 2");
    end
    if (DATA_WIDTH < 12) begin : g_bad_data
        $error("DATA_WIDTH must hold an RGB444 word");
    end
    if ((FB_WIDTH * FB_HEIGHT) > (1 << ADDR_WIDTH)) begin : g_bad_addr
        $error("frame buffer does not fit in ADDR_WIDTH");
    end

    logic [DIV_W-1:0]      div_q;
    logic [H_W-1:0]        h_q;
    logic [V_W-1:0]        v_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    // Address-stage copies of the per-position flags, consumed by the output stage.
    logic vis_d;
    logic hs_d;
    logic vs_d;
    logic origin_d;

    logic                  tick_c;
    logic                  h_wrap_c;
    logic                  v_wrap_c;
    logic                  visible_c;
    logic                  hs_raw_c;
    logic                  vs_raw_c;
    logic                  origin_c;
    logic [ADDR_WIDTH-1:0] addr_c;

    always_comb begin
        tick_c    = (div_q == DIV_W'(CLK_DIV - 1));
        h_wrap_c  = (h_q == H_W'(H_TOTAL - 1));
        v_wrap_c  = (v_q == V_W'(V_TOTAL - 1));
        visible_c = (h_q < H_W'(H_ACTIVE)) && (v_q < V_W'(V_ACTIVE));
        hs_raw_c  = !((h_q >= H_W'(HS_START)) && (h_q < H_W'(HS_END)));
        vs_raw_c  = !((v_q >= V_W'(VS_START)) && (v_q < V_W'(VS_END)));
        origin_c  = (h_q == '0) && (v_q == '0);
        addr_c    = '0;
        if (visible_c) begin
            addr_c = ADDR_WIDTH'(v_q >> 1) * ADDR_WIDTH'(FB_WIDTH) + ADDR_WIDTH'(h_q >> 1);
        end
    end

    // Pixel-tick divider and raster counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= tick_c ? '0 : div_q + DIV_W'(1);
            if (tick_c) begin
                h_q <= h_wrap_c ? '0 : h_q + H_W'(1);
                if (h_wrap_c) begin
                    v_q <= v_wrap_c ? '0 : v_q + V_W'(1);
                end
            end
        end
    end

    // Address stage: issue the VRAM read and delay the position flags by one tick.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q   <= '0;
            vis_d    <= 1'b0;
            hs_d     <= 1'b1;
            vs_d     <= 1'b1;
            origin_d <= 1'b0;
        end else if (tick_c) begin
            addr_q   <= addr_c;
            vis_d    <= visible_c;
            hs_d     <= hs_raw_c;
            vs_d     <= vs_raw_c;
            origin_d <= origin_c;
        end
    end

    assign vram.pixel_read_address_o = addr_q;

    // Output stage: RAM data has settled for CLK_DIV-1 cycles by the next tick.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hsync_o       <= 1'b1;
            vsync_o       <= 1'b1;
            active_o      <= 1'b0;
            red_o         <= '0;
            green_o       <= '0;
            blue_o        <= '0;
            frame_start_o <= 1'b0;
        end else begin
            frame_start_o <= tick_c && origin_d;
            if (tick_c) begin
                hsync_o  <= hs_d;
                vsync_o  <= vs_d;
                active_o <= vis_d;
                red_o    <= vis_d ? vram.pixel_data_i[11:8] : 4'h0;
                green_o  <= vis_d ? vram.pixel_data_i[7:4]  : 4'h0;
                blue_o   <= vis_d ? vram.pixel_data_i[3:0]  : 4'h0;
            end
        end
    end

endmodule

// File: tb/tb_vram_display_reader.sv
// Scoreboard bench for vram_display_reader on a reduced raster (24x16 ticks, 8x6 frame buffer).
module tb_vram_display_reader;

    localparam int unsigned CLK_DIV  = 3;
    localparam int unsigned H_ACTIVE = 16;
    localparam int unsigned H_FRONT  = 2;
    localparam int unsigned H_SYNC   = 4;
    localparam int unsigned H_BACK   = 2;
    localparam int unsigned V_ACTIVE = 12;
    localparam int unsigned V_FRONT  = 1;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BACK   = 1;
    localparam int unsigned FB_W     = 8;
    localparam int unsigned FB_H     = 6;
    localparam int unsigned H_TOTAL  = 24;
    localparam int unsigned V_TOTAL  = 16;
    localparam int unsigned FRAME    = H_TOTAL * V_TOTAL;
    localparam logic [14:0] RESET_OUT = 15'h6000;

    logic clk_i = 1'b0;
    logic reset_i = 1'b1;
    logic hsync_o, vsync_o, active_o, frame_start_o;
    logic [3:0] red_o, green_o, blue_o;

    vram_display_reader_if #(.ADDR_WIDTH(17), .DATA_WIDTH(12)) vram_bus ();

    vram_display_reader #(
        .ADDR_WIDTH(17), .DATA_WIDTH(12), .FB_WIDTH(FB_W), .FB_HEIGHT(FB_H), .CLK_DIV(CLK_DIV),
        .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .vram(vram_bus.master),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .red_o(red_o), .green_o(green_o),
        .blue_o(blue_o), .active_o(active_o), .frame_start_o(frame_start_o)
    );

    always #5 clk_i = ~clk_i;

    // RAM model: data = address[11:0], one cycle after the address.
    always @(posedge clk_i) vram_bus.pixel_data_i <= 12'(vram_bus.pixel_read_address_o);

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [14:0] sb_q[$];
    logic [16:0] frame_addr [FRAME];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] model_addr(input int unsigned p);
        int unsigned h = p % H_TOTAL;
        int unsigned v = (p / H_TOTAL) % V_TOTAL;
        if (h < H_ACTIVE && v < V_ACTIVE) return 17'((v / 2) * FB_W + h / 2);
        return 17'd0;
    endfunction

    function automatic logic [14:0] model_out(input int unsigned p);
        int unsigned h = p % H_TOTAL;
        int unsigned v = (p / H_TOTAL) % V_TOTAL;
        logic hs  = !(h >= 18 && h <= 21);
        logic vs  = !(v >= 13 && v <= 14);
        logic act = (h < H_ACTIVE && v < V_ACTIVE);
        logic [16:0] a = model_addr(p);
        logic [11:0] col = act ? a[11:0] : 12'h000;
        return {hs, vs, act, col};
    endfunction

    function automatic logic [14:0] observed();
        return {hsync_o, vsync_o, active_o, red_o, green_o, blue_o};
    endfunction

    task automatic hold_reset(input int unsigned cycles);
        reset_i = 1'b1;
        repeat (cycles) begin
            @(posedge clk_i); #1;
            check_val("rst_out", 32'(observed()), 32'(RESET_OUT));
            check_val("rst_addr", 32'(vram_bus.pixel_read_address_o), 32'd0);
            check_val("rst_fs", 32'(frame_start_o), 32'd0);
        end
        reset_i = 1'b0;
    endtask

    // Runs n_ticks pixel ticks from reset release, checking every clock cycle.
    task automatic run_ticks(input int unsigned n_ticks, input bit record);
        int unsigned n = 0, k = 0, fs_seen = 0, first_chg = 0;
        int unsigned hfall_n = 0, vfall_n = 0, line_n = 0, hper_cnt = 0, vper_cnt = 0;
        bit have_hfall = 0, have_vfall = 0, have_line = 0, changed = 0;
        logic prev_hs = 1'b1, prev_vs = 1'b1;
        logic [14:0] exp_out = RESET_OUT;
        logic [14:0] obs;
        logic [16:0] exp_addr = '0;
        logic [16:0] dut_addr;
        bit tick, fs_exp;
        sb_q.delete();
        while (k < n_ticks) begin
            @(posedge clk_i); #1;
            n++;
            tick = (n % CLK_DIV == 0);
            obs = observed();
            dut_addr = vram_bus.pixel_read_address_o;
            if (tick) begin
                int unsigned p, h, v;
                k++;
                p = k - 1;
                h = p % H_TOTAL;
                v = (p / H_TOTAL) % V_TOTAL;
                exp_addr = model_addr(p);
                sb_q.push_back(model_out(p));
                if (h == 0  && v == 0)  check_val("addr_0_0", 32'(dut_addr), 32'd0);
                if (h == 1  && v == 1)  check_val("addr_1_1", 32'(dut_addr), 32'd0);
                if (h == 2  && v == 1)  check_val("addr_2_1", 32'(dut_addr), 32'd1);
                if (h == 0  && v == 2)  check_val("addr_0_2", 32'(dut_addr), 32'd8);
                if (h == 15 && v == 11) check_val("addr_max", 32'(dut_addr), 32'd47);
                if (h == 20 && v == 3)  check_val("addr_hblank", 32'(dut_addr), 32'd0);
                if (h == 5  && v == 13) check_val("addr_vblank", 32'(dut_addr), 32'd0);
                if (record && p < FRAME) frame_addr[p] = dut_addr;
                if (record && p >= FRAME && p < 2 * FRAME)
                    check_val("frame2_addr", 32'(dut_addr), 32'(frame_addr[p - FRAME]));
                if (k >= 2) begin
                    int unsigned q = k - 2;
                    int unsigned qh = q % H_TOTAL;
                    int unsigned qv = (q / H_TOTAL) % V_TOTAL;
                    exp_out = sb_q.pop_front();
                    if (qh == 0) begin line_n = n; have_line = 1; end
                    if (qh == 4 && qv == 0) check_val("px_4_0_col", 32'(obs[11:0]), 32'h002);
                    if (qh == 16 && qv == 0) check_val("px_blank", 32'(obs[12:0]), 32'd0);
                end
            end
            fs_exp = tick && (k >= 2) && ((k - 2) % FRAME == 0);
            check_val("addr", 32'(dut_addr), 32'(exp_addr));
            check_val("out", 32'(obs), 32'(exp_out));
            check_val("frame_start", 32'(frame_start_o), 32'(fs_exp));
            if (frame_start_o) fs_seen++;
            if (!changed && (obs != RESET_OUT || frame_start_o)) begin
                changed = 1;
                first_chg = n;
            end
            if (prev_hs && !obs[14]) begin
                if (have_hfall) begin
                    check_val("h_period", 32'(n - hfall_n), 32'(H_TOTAL * CLK_DIV));
                    hper_cnt++;
                end
                if (have_line) check_val("h_fall_ofs", 32'(n - line_n), 32'(18 * CLK_DIV));
                hfall_n = n;
                have_hfall = 1;
            end
            if (!prev_hs && obs[14] && have_hfall)
                check_val("h_low", 32'(n - hfall_n), 32'(H_SYNC * CLK_DIV));
            if (prev_vs && !obs[13]) begin
                if (have_vfall) begin
                    check_val("v_period", 32'(n - vfall_n), 32'(FRAME * CLK_DIV));
                    vper_cnt++;
                end
                vfall_n = n;
                have_vfall = 1;
            end
            if (!prev_vs && obs[13] && have_vfall)
                check_val("v_low", 32'(n - vfall_n), 32'(V_SYNC * H_TOTAL * CLK_DIV));
            prev_hs = obs[14];
            prev_vs = obs[13];
        end
        check_val("first_change", 32'(first_chg), 32'(2 * CLK_DIV));
        check_val("fs_count", 32'(fs_seen), 32'((k - 2) / FRAME + 1));
        check_val("hsync_seen", 32'(hper_cnt > 0), 32'd1);
        if (record) check_val("vsync_seen", 32'(vper_cnt), 32'd1);
    endtask

    initial begin
        hold_reset(5);
        run_ticks(2 * FRAME + 60, 1'b1);
        hold_reset(5);
        run_ticks(200, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vram_display_reader.md
# vram_display_reader

- Read side of the camera frame buffer.
- Generates 640x480@60 VGA timing from the single system clock.
- Fetches 320x240 RGB444 pixels from the VRAM read port at 2x scaling in both axes, and drives sync plus colour outputs.
- Sits between the VRAM read port and the board VGA connector.

## Interface
Parameters:
- ADDR_WIDTH, 17, VRAM address width.
- DATA_WIDTH, 12, VRAM word width; bits 11:8 red, 7:4 green, 3:0 blue.
- FB_WIDTH, 320, frame buffer width in pixels.
- FB_HEIGHT, 240, frame buffer height in pixels.
- CLK_DIV, 4, clk_i cycles per pixel tick; must be ≥2.
- H_ACTIVE/H_FRONT/H_SYNC/H_BACK, 640/16/96/48, horizontal timing in ticks.
- V_ACTIVE/V_FRONT/V_SYNC/V_BACK, 480/10/2/33, vertical timing in lines.

Ports:
- clk_i, input, 1, system clock; this is the only clock.
- reset_i, input, 1, synchronous, active-high reset.
- pixel_data_i, input, DATA_WIDTH, VRAM read data; valid one clk_i cycle after the address.
- pixel_read_address_o, output, ADDR_WIDTH, VRAM read address.
- hsync_o, output, 1, horizontal sync; active low.
- vsync_o, output, 1, vertical sync; active low.
- red_o, output, 4, red channel.
- green_o, output, 4, green channel.
- blue_o, output, 4, blue channel.
- active_o, output, 1, high while displayed colour is in the visible region.
- frame_start_o, output, 1, one-clk pulse when pixel (0,0) appears on the outputs.

## Operation
- Tick divider counts 0..CLK_DIV-1. The tick asserts for one clk_i cycle when the divider equals CLK_DIV-1.
- h_count runs 0..H_TOTAL-1, with H_TOTAL = 800. It advances on each tick and wraps to 0.
- v_count runs 0..V_TOTAL-1, with V_TOTAL = 525. It advances on the tick where h_count wraps, and wraps to 0 after line 524.
- The visible region is h_count < H_ACTIVE and v_count < V_ACTIVE.
- Raw hsync is low for h_count in [656, 751].
- Raw vsync is low for v_count in [490, 491].
- Address is registered on each tick from the current counters:
  - Visible region: (v_count>>1)*FB_WIDTH + (h_count>>1).
  - Outside the visible region: 0.
  - The result must fit in ADDR_WIDTH bits; maximum is 76799.
  - An incremental implementation (row base register plus column offset) is permitted. Results must be identical to the formula.
- Output stage is registered on the tick following the address tick:
  - hsync_o and vsync_o take the delayed raw syncs.
  - active_o takes the delayed visible flag.
  - Colour takes pixel_data_i fields when the delayed visible flag is 1; otherwise 0.
- frame_start_o is high for exactly the one clk_i cycle in which the output stage loads the (0,0) pixel.
- No back-pressure and no handshakes. VRAM is read every tick regardless of camera write activity; tearing is acceptable.

## Timing
Reset:
- Divider, h_count, v_count and pixel_read_address_o are 0.
- hsync_o and vsync_o are 1.
- red_o, green_o, blue_o, active_o and frame_start_o are 0.

Start-up:
- First tick occurs CLK_DIV cycles after reset_i deasserts.
- On that tick the counters step from (0,0) to (1,0). Simultaneously the address for (0,0), which is 0, is registered.

Latency:
- Counter state to address: 1 tick.
- Address to colour output: 1 tick.
- RAM data is sampled at least CLK_DIV-1 clk cycles after the address, so a 1-cycle RAM latency is covered.
- Syncs and active_o carry the same 1-tick pipeline delay as colour, keeping all outputs aligned.

Outputs:
- All outputs change only on tick cycles.
- Exception: frame_start_o deasserts on the clk_i cycle after it asserts.

Wrap-around:
- On the tick where h_count = 799, h_count goes to 0 and v_count increments in the same cycle.
- At (799, 524) both counters go to 0.

Reset mid-frame:
- Takes effect on the next clk_i edge.
- All state returns to reset values and no partial pixel is emitted.
- Timing restarts exactly as from power-up.

## Test plan
- **Reset:** hold reset_i 5 cycles mid-frame, then release.
  - Required: all outputs equal their reset values during reset.
  - Required: first output change occurs 2*CLK_DIV cycles after release.
- **Horizontal timing:**
  - Required: hsync_o period is 3200 clk_i cycles.
  - Required: low time is 384 cycles.
  - Required: the falling edge comes 656 ticks after the output pixel (0,y).
- **Vertical timing:**
  - Required: vsync_o period is 525 lines (1,680,000 cycles) with low time of 2 lines.
  - Required: frame_start_o pulses exactly once per frame.
- **Addressing:** check pixel_read_address_o at several counter positions.
  - (0,0) → 0.
  - (1,1) → 0.
  - (2,1) → 1.
  - (0,2) → 320.
  - (639,479) → 76799.
  - Any blanking position → 0.
- **Data path:** behavioural RAM model returns data = address[11:0] one cycle late.
  - At output pixel (4,0), colour = 0x002, giving red 0, green 0, blue 2.
  - Outside the visible region, colour = 0 with active_o = 0.
- **Frame wrap:** run 2 full frames.
  - Required: no glitch at the (799,524)→(0,0) transition.
  - Required: the second frame's address sequence is identical to the first.
